// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the data-memory responder
package dmem_pkg;
  localparam int BW = 64;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  function automatic logic misaligned(logic [2:0] lane, size_t sz);
    return sz == SZ_H ? lane[0] : sz == SZ_W ? |lane[1:0] : sz == SZ_D ? |lane : 1'b0;
  endfunction
  function automatic logic [7:0] byte_mask(size_t sz);
    return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0f : 8'hff;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage load/store request and response bundle
interface dmem_responder_if #(parameter int BUS_WIDTH = 64);
  logic                 req_valid;
  logic                 req_we;
  logic [BUS_WIDTH-1:0] req_addr;
  logic [BUS_WIDTH-1:0] req_wdata;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic                 stall;
  logic                 resp_valid;
  logic [BUS_WIDTH-1:0] resp_rdata;
  logic                 err;
  modport master(output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
                 input stall, resp_valid, resp_rdata, err);
  modport slave(input req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
                output stall, resp_valid, resp_rdata, err);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load shift/mask/extend and store byte-lane alignment
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] rd_dword,
  input  logic [2:0]  lane,
  input  size_t       size,
  input  logic        uns,
  input  logic [63:0] wdata,
  output logic [63:0] ld_data,
  output logic [7:0]  be,
  output logic [63:0] st_data
);
  logic [63:0] sh;
  logic        sb;
  assign sh = rd_dword >> {lane, 3'b000};
  always_comb begin
    sb = ~uns & (size == SZ_B ? sh[7] : size == SZ_H ? sh[15] : sh[31]);
    ld_data = size == SZ_B ? {{56{sb}}, sh[7:0]} :
              size == SZ_H ? {{48{sb}}, sh[15:0]} :
              size == SZ_W ? {{32{sb}}, sh[31:0]} : sh;
  end
  assign st_data = wdata << {lane, 3'b000};
  assign be = byte_mask(size) << lane;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: variable-latency data memory with stall, sized loads and merged stores
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int BUS_WIDTH   = 64,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  dmem_responder_if.slave bus
);
  localparam int AW3 = ADDR_WIDTH + 3;
  state_t               st;
  logic [3:0]           cnt;
  logic                 we_q, uns_q, err_q;
  logic [AW3-1:0]       addr_q;
  logic [BUS_WIDTH-1:0] wdata_q, rdata_q;
  size_t                size_q;
  logic [BUS_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic                 idle, enter, c_we, c_uns, c_mis, unused_hi;
  logic [AW3-1:0]       c_addr;
  logic [BUS_WIDTH-1:0] c_wdata, ld_data, st_data;
  size_t                c_size;
  logic [7:0]           be;
  // With zero wait states RESP is entered straight from IDLE, so the live request is used
  assign idle    = st == ST_IDLE;
  assign c_we    = idle ? bus.req_we : we_q;
  assign c_uns   = idle ? bus.req_unsigned : uns_q;
  assign c_addr  = idle ? bus.req_addr[AW3-1:0] : addr_q;
  assign c_wdata = idle ? bus.req_wdata : wdata_q;
  assign c_size  = idle ? size_t'(bus.req_size) : size_q;
  assign c_mis   = misaligned(c_addr[2:0], c_size);
  assign enter   = idle ? bus.req_valid && WAIT_CYCLES == 0 : st == ST_WAIT && cnt == 4'd1;
  assign unused_hi = ^bus.req_addr[BUS_WIDTH-1:AW3];
  assign bus.stall      = (idle && bus.req_valid) || st == ST_WAIT;
  assign bus.resp_valid = st == ST_RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.err        = err_q;
  dmem_lane_align u_align (
    .rd_dword(mem[c_addr[AW3-1:3]]),
    .lane    (c_addr[2:0]),
    .size    (c_size),
    .uns     (c_uns),
    .wdata   (c_wdata),
    .ld_data (ld_data),
    .be      (be),
    .st_data (st_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_B;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (enter) begin
        err_q   <= c_mis;
        rdata_q <= (c_we || c_mis) ? '0 : ld_data;
      end
      case (st)
        ST_IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          uns_q   <= bus.req_unsigned;
          addr_q  <= bus.req_addr[AW3-1:0];
          wdata_q <= bus.req_wdata;
          size_q  <= size_t'(bus.req_size);
          cnt     <= 4'(WAIT_CYCLES);
          st      <= WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) st <= ST_RESP;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
  // Storage is never reset; the rst term keeps an abandoned access from writing
  always_ff @(posedge clk) begin
    if (enter && !rst && c_we && !c_mis)
      for (int i = 0; i < 8; i++)
        if (be[i]) mem[c_addr[AW3-1:3]][8*i+:8] <= st_data[8*i+:8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench against a byte-addressed reference memory
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if b0 ();
  dmem_responder_if b2 ();
  dmem_responder #(.WAIT_CYCLES(0)) d0 (.clk(clk), .rst(rst0), .bus(b0));
  dmem_responder #(.WAIT_CYCLES(2)) d2 (.clk(clk), .rst(rst2), .bus(b2));

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t q0[$];
  exp_t q2[$];
  exp_t m0, m2;
  logic [7:0] ref_mem [8192];
  int checks = 0, errors = 0, sc0 = 0, sc2 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-addressed model: the space wraps at 8 KiB, aligned accesses never straddle
  task automatic model(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input int size, input logic uns, output exp_t e);
    int n = 1 << size;
    int a = int'(addr[12:0]);
    logic [63:0] v = '0;
    e.rdata = '0;
    e.err = 1'b0;
    if (a % n != 0) begin
      e.err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++)
      if (we) ref_mem[a+i] = wdata[8*i+:8];
      else v[8*i+:8] = ref_mem[a+i];
    if (!we) begin
      if (!uns && size < 3 && v[8*n-1])
        for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
      e.rdata = v;
    end
  endtask

  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input int size, input logic uns);
    exp_t e;
    bit f0 = 0, f2 = 0;
    int t = 0;
    model(we, addr, wdata, size, uns, e);
    q0.push_back(e);
    q2.push_back(e);
    @(posedge clk);
    #1;
    b0.req_we = we; b0.req_addr = addr; b0.req_wdata = wdata;
    b0.req_size = 2'(size); b0.req_unsigned = uns; b0.req_valid = 1'b1;
    b2.req_we = we; b2.req_addr = addr; b2.req_wdata = wdata;
    b2.req_size = 2'(size); b2.req_unsigned = uns; b2.req_valid = 1'b1;
    while (!(f0 && f2) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
      if (b0.resp_valid) begin f0 = 1; b0.req_valid = 1'b0; end
      if (b2.resp_valid) begin f2 = 1; b2.req_valid = 1'b0; end
    end
    checks++;
    if (!(f0 && f2)) begin
      errors++;
      $display("FAIL timeout: resp seen w0=%0d w2=%0d required both", f0, f2);
      b0.req_valid = 1'b0;
      b2.req_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst0) sc0 = 0;
    else begin
      if (b0.stall) sc0++;
      if (b0.resp_valid) begin
        chk("overlap0", b0.stall, 0);
        if (q0.size() == 0) chk("spurious_resp0", 1, 0);
        else begin
          m0 = q0.pop_front();
          chk("rdata0", b0.resp_rdata, m0.rdata);
          chk("err0", b0.err, m0.err);
          chk("stall_cycles0", sc0, 1);
        end
        sc0 = 0;
      end
    end
    if (rst2) sc2 = 0;
    else begin
      if (b2.stall) sc2++;
      if (b2.resp_valid) begin
        chk("overlap2", b2.stall, 0);
        if (q2.size() == 0) chk("spurious_resp2", 1, 0);
        else begin
          m2 = q2.pop_front();
          chk("rdata2", b2.resp_rdata, m2.rdata);
          chk("err2", b2.err, m2.err);
          chk("stall_cycles2", sc2, 3);
        end
        sc2 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int sz;
    b0.req_valid = 0; b0.req_we = 0; b0.req_addr = 0; b0.req_wdata = 0;
    b0.req_size = 0; b0.req_unsigned = 0;
    b2.req_valid = 0; b2.req_we = 0; b2.req_addr = 0; b2.req_wdata = 0;
    b2.req_size = 0; b2.req_unsigned = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall0", b0.stall, 0);
    chk("rst_valid0", b0.resp_valid, 0);
    chk("rst_rdata0", b0.resp_rdata, 0);
    chk("rst_err0", b0.err, 0);
    chk("rst_stall2", b2.stall, 0);
    chk("rst_valid2", b2.resp_valid, 0);
    chk("rst_rdata2", b2.resp_rdata, 0);
    chk("rst_err2", b2.err, 0);
    rst0 = 0;
    rst2 = 0;
    for (int d = 0; d < 32; d++) issue(1, 64'(d * 8), {$urandom, $urandom}, 3, 0);
    issue(1, 64'h40, 64'h1122334455667788, 3, 0);
    issue(0, 64'h40, 0, 3, 0);
    issue(0, 64'h40, 0, 0, 0);
    issue(0, 64'h40, 0, 0, 1);
    issue(0, 64'h47, 0, 0, 0);
    issue(1, 64'h42, 64'hBEEF, 1, 0);
    issue(0, 64'h40, 0, 3, 0);
    issue(0, 64'h41, 0, 2, 0);
    issue(0, 64'h40, 0, 3, 0);
    issue(1, 64'h43, 64'h5A5A, 1, 0);
    issue(0, 64'h40, 0, 3, 0);
    issue(1, 64'h40 + (64'h1 << 13), 64'hCAFEF00DDEADBEEF, 3, 0);
    issue(0, 64'h44, 0, 2, 0);
    issue(0, 64'h42, 0, 1, 1);
    for (int k = 0; k < 300; k++) begin
      sz = $urandom_range(0, 3);
      a = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~(64'((1 << sz) - 1));
      if ($urandom_range(0, 3) == 0) a = a | ({$urandom, $urandom} << 13);
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz, 1'($urandom_range(0, 1)));
    end
    issue(0, 64'h40, 0, 3, 0);
    @(posedge clk);
    #1;
    b2.req_we = 1; b2.req_addr = 64'h80; b2.req_wdata = 64'h0123456789ABCDEF;
    b2.req_size = 2'd3; b2.req_unsigned = 0; b2.req_valid = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid_wait_stall", b2.stall, 1);
    rst2 = 1;
    b2.req_valid = 0;
    #1;
    chk("abort_stall", b2.stall, 0);
    chk("abort_valid", b2.resp_valid, 0);
    chk("abort_rdata", b2.resp_rdata, 0);
    chk("abort_err", b2.err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst2 = 0;
    issue(0, 64'h80, 0, 3, 0);
    issue(0, 64'h84, 0, 2, 1);
    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
